// File: rtl/byte_cmp_seq_pkg.sv
// Shared cells package for the byte-serial comparator: state encoding and defaults.
package byte_cmp_seq_pkg;

  localparam int unsigned DEFAULT_NUM_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_t;

  // Only the most significant slice of a signed compare carries the sign bit.
  function automatic logic slice_msb_inv(input logic signed_flag, input logic last_slice);
    return signed_flag & last_slice;
  endfunction

endpackage

// File: rtl/byte_cmp_seq_lt.sv
// 8-bit less-than; inverting bit 7 of both operands turns it into a signed compare.
module byte_lt (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       msb_inv_i,
  output logic       lt_o
);

  logic [7:0] a_s;
  logic [7:0] b_s;

  // Bias both operands, then a plain unsigned compare.
  always_comb begin
    a_s  = {a_i[7] ^ msb_inv_i, a_i[6:0]};
    b_s  = {b_i[7] ^ msb_inv_i, b_i[6:0]};
    lt_o = (a_s < b_s);
  end

endmodule

// File: rtl/byte_cmp_seq.sv
// Byte-serial equal / less-than comparator, LSB slice first; the last differing slice decides lt.
module byte_cmp_seq
  import byte_cmp_seq_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int IDX_BITS  = $clog2(NUM_BYTES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                is_signed,
  output logic                ready,
  output logic [IDX_BITS-1:0] byte_idx,
  input  logic [7:0]          a_byte,
  input  logic [7:0]          b_byte,
  input  logic                byte_ne,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                eq,
  output logic                lt
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_BYTES - 1);

  cmp_state_t          state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                eq_q, eq_d;
  logic                lt_q, lt_d;
  logic                sgn_q, sgn_d;
  logic                valid_q, valid_d;

  logic                last_s;
  logic                slice_lt_s;
  logic                accept_s;

  assign last_s   = (idx_q == LAST_IDX);
  // A result is only handed over once out_valid is actually visible.
  assign ready    = (state_q == ST_IDLE) |
                    ((state_q == ST_DONE) & valid_q & out_ready);
  assign accept_s = start & ready;

  byte_lt u_byte_lt (
    .a_i       (a_byte),
    .b_i       (b_byte),
    .msb_inv_i (slice_msb_inv(sgn_q, last_s)),
    .lt_o      (slice_lt_s)
  );

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    sgn_d   = sgn_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RUN;
          idx_d   = '0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          sgn_d   = is_signed;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (byte_ne) begin
          eq_d = 1'b0;
          lt_d = slice_lt_s;
        end else begin
          lt_d = lt_q;
        end
        if (last_s) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + IDX_BITS'(1);
        end
      end
      ST_DONE: begin
        valid_d = 1'b1;
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = ST_RUN;
            idx_d   = '0;
            eq_d    = 1'b1;
            lt_d    = 1'b0;
            sgn_d   = is_signed;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      sgn_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      sgn_q   <= sgn_d;
      valid_q <= valid_d;
    end
  end

  assign byte_idx  = idx_q;
  assign out_valid = valid_q;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_byte_cmp_seq.sv
// Randomized bench for byte_cmp_seq against a word-level behavioural model.
module tb_byte_cmp_seq;

  localparam int N  = 4;
  localparam int IB = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic          out_ready = 1'b0;
  logic [IB-1:0] byte_idx;
  logic [7:0]    a_byte, b_byte;
  logic          byte_ne;
  logic          ready, out_valid, eq, lt;
  logic [31:0]   op_a = 32'h0, op_b = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  byte_cmp_seq #(.NUM_BYTES(N), .IDX_BITS(IB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .ready(ready), .byte_idx(byte_idx), .a_byte(a_byte), .b_byte(b_byte),
    .byte_ne(byte_ne), .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .lt(lt)
  );

  // Upstream slice mux and difference detector.
  always_comb begin
    a_byte  = op_a[int'(byte_idx) * 8 +: 8];
    b_byte  = op_b[int'(byte_idx) * 8 +: 8];
    byte_ne = (a_byte != b_byte);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: a result appears N+1 edges after acceptance.
  bit m_pend = 1'b0, m_valid = 1'b0, m_eq = 1'b0, m_lt = 1'b0, r_eq = 1'b0, r_lt = 1'b0;
  int m_cnt = 0;

  always @(posedge clk) begin
    bit acc;
    acc = start && !m_pend && (!m_valid || out_ready);
    if (!reset_n) begin
      m_pend = 1'b0; m_valid = 1'b0; m_eq = 1'b0; m_lt = 1'b0; m_cnt = 0;
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_pend = 1'b0; m_valid = 1'b1; m_eq = r_eq; m_lt = r_lt;
        end
      end
      if (acc) begin
        m_pend = 1'b1;
        m_cnt  = N + 1;
        r_eq   = (op_a == op_b);
        r_lt   = is_signed ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(!m_pend && (!m_valid || out_ready)));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("byte_idx", 32'(byte_idx), (m_pend && m_cnt >= 2) ? 32'(N + 1 - m_cnt) : 32'd0);
      if (!m_pend) begin
        chk("eq", 32'(eq), 32'(m_eq));
        chk("lt", 32'(lt), 32'(m_lt));
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic o_eq, output logic o_lt, output int lat);
    op_a = a; op_b = b; is_signed = s; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; is_signed = ~s;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    o_eq = eq; o_lt = lt;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic e_s, l_s;
  int   lat_s;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_eq", 32'(eq), 32'd0);
    chk("rst_lt", 32'(lt), 32'd0);
    chk("rst_idx", 32'(byte_idx), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h0000_0005, 32'h0000_0005, 1'b0, e_s, l_s, lat_s);
    chk("eqcase_lat", 32'(lat_s), 32'd5);
    chk("eqcase_eq", 32'(e_s), 32'd1);
    chk("eqcase_lt", 32'(l_s), 32'd0);

    run_op(32'h0100_0000, 32'h00FF_FFFF, 1'b0, e_s, l_s, lat_s);
    chk("msb_override_eq", 32'(e_s), 32'd0);
    chk("msb_override_lt", 32'(l_s), 32'd0);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, e_s, l_s, lat_s);
    chk("signed_neg_eq", 32'(e_s), 32'd0);
    chk("signed_neg_lt", 32'(l_s), 32'd1);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, e_s, l_s, lat_s);
    chk("unsigned_big_eq", 32'(e_s), 32'd0);
    chk("unsigned_big_lt", 32'(l_s), 32'd0);

    // Held result with ignored starts, then back-to-back restart.
    op_a = 32'h1234_5678; op_b = 32'h1234_5679; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat_s = 0;
    while (!out_valid && lat_s < 20) begin
      @(posedge clk); #1;
      lat_s++;
    end
    chk("hold_lat", 32'(lat_s), 32'd5);
    op_a = 32'h8000_0000; op_b = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      start = 1'(i & 1);
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_eq", 32'(eq), 32'd0);
      chk("hold_lt", 32'(lt), 32'd1);
    end
    out_ready = 1'b1; start = 1'b1; is_signed = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0; is_signed = 1'b0;
    chk("b2b_valid_drop", 32'(out_valid), 32'd0);
    lat_s = 0;
    while (!out_valid && lat_s < 20) begin
      @(posedge clk); #1;
      lat_s++;
    end
    chk("b2b_lat", 32'(lat_s), 32'd5);
    chk("b2b_lt", 32'(lt), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Abort mid-operation.
    op_a = 32'h0000_0001; op_b = 32'h0000_0002; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idx2", 32'(byte_idx), 32'd2);
    reset_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_idx", 32'(byte_idx), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (!m_pend) begin
        op_a = $urandom;
        case ($urandom_range(0, 3))
          0: op_b = op_a;
          1: op_b = op_a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
          2: op_b = op_a ^ 32'h8000_0000;
          default: op_b = $urandom;
        endcase
      end
      start     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      is_signed = 1'($urandom_range(0, 1));
      reset_n   = ($urandom_range(0, 79) != 0);
      @(posedge clk); #1;
    end

    reset_n = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
